// File: rtl/nanov_regfile_serial.sv
// nanov_regfile_serial: digit-serial register file for a bit/nibble-serial RISC-V core.
//
// Every register x1..NUM_REGS-1 is an XLEN-bit ring that rotates right by DW bits on
// each enabled cycle, so the digit currently presented is always bits [DW-1:0].
// A shared digit counter tracks which digit of the word is on the read ports.
// XLEN must be a multiple of DW and larger than DW.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset, clears all registers and the digit counter
//   en         advance: rotate registers and the digit counter by one digit
//   rs1, rs2   read selects; rs1_data/rs2_data present the current digit (combinational)
//   rd         write select; wr_en/wr_data write the current digit of rd when en=1
//   fwd_en     enable same-cycle bypass of wr_data to matching read ports
//   digit      index of the digit currently presented (0 = least significant)
//   word_done  high while en=1 on the last digit of the word
//
// Build option: define NANOV_REGFILE_CONST_REGS_EN to make x3 a read-only constant
// 0x00001000 and x4 a read-only constant 0x10000000 (no storage, no bypass, writes dropped).

module nanov_regfile_serial #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned DW            = 1,
  parameter int unsigned NUM_REGS      = 16,
  parameter int unsigned REG_ADDR_BITS = 4,
  localparam int unsigned NumDigits    = XLEN / DW,
  localparam int unsigned DigitW       = (NumDigits > 1) ? $clog2(NumDigits) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [REG_ADDR_BITS-1:0] rs1,
  input  logic [REG_ADDR_BITS-1:0] rs2,
  input  logic [REG_ADDR_BITS-1:0] rd,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     fwd_en,
  output logic [DW-1:0]            rs1_data,
  output logic [DW-1:0]            rs2_data,
  output logic [DigitW-1:0]        digit,
  output logic                     word_done
);

`ifdef NANOV_REGFILE_CONST_REGS_EN
  localparam bit ConstEn = 1'b1;
`else
  localparam bit ConstEn = 1'b0;
`endif

  localparam logic [DigitW-1:0] LastDigit = DigitW'(NumDigits - 1);
  localparam logic [XLEN-1:0]   ConstX3   = XLEN'(32'h0000_1000);
  localparam logic [XLEN-1:0]   ConstX4   = XLEN'(32'h1000_0000);

  logic [DigitW-1:0] digit_q, digit_d;

  // Current digit of every register; index 0 is hard-wired zero.
  logic [DW-1:0] cur_digit [NUM_REGS];

  // Digit counter
  always_comb begin
    digit_d = digit_q;
    if (en) begin
      digit_d = (digit_q == LastDigit) ? '0 : digit_q + DigitW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit     = digit_q;
  assign word_done = en && (digit_q == LastDigit);

  // Register rings
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign cur_digit[i] = '0;
    end else if (ConstEn && (i == 3 || i == 4)) begin : g_const
      // Constants are serialised by picking the digit selected by the shared counter.
      logic [XLEN-1:0] shifted;
      assign shifted      = ((i == 3) ? ConstX3 : ConstX4) >> (32'(digit_q) * DW);
      assign cur_digit[i] = shifted[DW-1:0];
    end else begin : g_store
      logic [XLEN-1:0] reg_q, reg_d;
      logic            wr_hit;

      assign wr_hit = wr_en && (rd == REG_ADDR_BITS'(i));

      // The outgoing digit re-enters at the top unless it is being overwritten.
      always_comb begin
        reg_d = reg_q;
        if (en) begin
          reg_d = {(wr_hit ? wr_data : reg_q[DW-1:0]), reg_q[XLEN-1:DW]};
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign cur_digit[i] = reg_q[DW-1:0];
    end
  end

  // Read ports with optional write-to-read bypass
  logic rd_is_const;
  logic byp_ok;

  always_comb begin
    rd_is_const = ConstEn && ((rd == REG_ADDR_BITS'(3)) || (rd == REG_ADDR_BITS'(4)));
    byp_ok      = fwd_en && wr_en && en && (rd != '0) && (32'(rd) < NUM_REGS) && !rd_is_const;

    rs1_data = '0;
    if (32'(rs1) < NUM_REGS) begin
      rs1_data = cur_digit[rs1];
    end
    if (byp_ok && (rs1 == rd)) begin
      rs1_data = wr_data;
    end

    rs2_data = '0;
    if (32'(rs2) < NUM_REGS) begin
      rs2_data = cur_digit[rs2];
    end
    if (byp_ok && (rs2 == rd)) begin
      rs2_data = wr_data;
    end
  end

endmodule

// File: tb/tb_nanov_regfile_serial.sv
// Testbench for nanov_regfile_serial (XLEN=32, DW=1, 16 registers).
// Stimulus pushes the expected outputs of each cycle into a queue; a monitor pops one
// entry per cycle at the falling edge and compares the enabled fields.

module tb_nanov_regfile_serial;

`ifdef NANOV_REGFILE_CONST_REGS_EN
  localparam bit ConstMode = 1'b1;
`else
  localparam bit ConstMode = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, wr_en, fwd_en;
  logic [3:0] rs1, rs2, rd;
  logic [0:0] wr_data;
  logic [0:0] rs1_data, rs2_data;
  logic [4:0] digit;
  logic       word_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nanov_regfile_serial #(
    .XLEN          (32),
    .DW            (1),
    .NUM_REGS      (16),
    .REG_ADDR_BITS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .fwd_en    (fwd_en),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .digit     (digit),
    .word_done (word_done)
  );

  typedef struct {
    string      name;
    bit         c1;
    logic       e1;
    bit         c2;
    logic       e2;
    bit         cd;
    logic [4:0] ed;
    bit         cw;
    logic       ew;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(input string n, input bit c1, input logic e1, input bit c2,
                              input logic e2, input bit cd, input int ed, input bit cw,
                              input logic ew);
    exp_t e;
    e.name = n; e.c1 = c1; e.e1 = e1; e.c2 = c2; e.e2 = e2;
    e.cd = cd; e.ed = 5'(ed); e.cw = cw; e.ew = ew;
    return e;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, expv, $time);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.c1) chk({e.name, ".rs1_data"}, 32'(rs1_data), 32'(e.e1));
        if (e.c2) chk({e.name, ".rs2_data"}, 32'(rs2_data), 32'(e.e2));
        if (e.cd) chk({e.name, ".digit"}, 32'(digit), 32'(e.ed));
        if (e.cw) chk({e.name, ".word_done"}, 32'(word_done), 32'(e.ew));
      end
    end
  end

  task automatic cyc(input logic i_rst, input logic i_en, input logic i_we,
                     input logic [3:0] i_rd, input logic i_wd, input logic i_fwd,
                     input logic [3:0] i_rs1, input logic [3:0] i_rs2, input exp_t e);
    @(posedge clk);
    #1;
    rst = i_rst; en = i_en; wr_en = i_we; rd = i_rd; wr_data = i_wd; fwd_en = i_fwd;
    rs1 = i_rs1; rs2 = i_rs2;
    exp_q.push_back(e);
  endtask

  // One full word pass; optional 5-cycle en=0 pause before digit pause_at (garbage
  // wr_data offered during the pause) and optional rs1 switch from digit sw_at onward.
  task automatic pass(input string n, input logic we, input logic [3:0] w_rd,
                      input logic [31:0] wv, input logic fwd,
                      input logic [3:0] r1, input logic [3:0] r2,
                      input bit c1, input logic [31:0] v1, input bit c2, input logic [31:0] v2,
                      input int pause_at, input int sw_at,
                      input logic [3:0] r1_alt, input logic [31:0] v1_alt);
    for (int k = 0; k < 32; k++) begin
      logic [3:0]  s1;
      logic [31:0] e1v;
      s1  = (sw_at >= 0 && k >= sw_at) ? r1_alt : r1;
      e1v = (sw_at >= 0 && k >= sw_at) ? v1_alt : v1;
      if (k == pause_at) begin
        repeat (5) cyc(1'b0, 1'b0, we, w_rd, ~wv[k], fwd, s1, r2,
                       mk({n, "_pause"}, c1, e1v[k], c2, v2[k], 1'b1, k, 1'b1, 1'b0));
      end
      cyc(1'b0, 1'b1, we, w_rd, wv[k], fwd, s1, r2,
          mk(n, c1, e1v[k], c2, v2[k], 1'b1, k, 1'b1, k == 31));
    end
  endtask

  localparam logic [31:0] X3Exp = ConstMode ? 32'h0000_1000 : 32'hCAFE_F00D;
  localparam logic [31:0] X4Exp = ConstMode ? 32'h1000_0000 : 32'h0000_0000;

  initial begin
    logic [31:0] beef;
    exp_t        none;
    beef = 32'hDEAD_BEEF;
    none = mk("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; rd = '0; wr_data = '0; fwd_en = 1'b0;
    rs1 = '0; rs2 = '0;

    cyc(1'b1, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 4'd5, 4'd1, none);
    cyc(1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 4'd5, 4'd1, none);
    cyc(1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 4'd5, 4'd1,
        mk("reset", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0));

    // x5 = DEADBEEF; x1 and x0 read zero meanwhile
    pass("wr_x5", 1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0, 4'd1, 4'd0,
         1'b1, 32'h0, 1'b1, 32'h0, -1, -1, 4'd0, 32'h0);
    // x1 = 0F0F1234 while reading x5 on both ports
    pass("rd_x5", 1'b1, 4'd1, 32'h0F0F_1234, 1'b0, 4'd5, 4'd5,
         1'b1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, -1, -1, 4'd0, 32'h0);
    // write all ones to x0
    pass("wr_x0", 1'b1, 4'd0, 32'hFFFF_FFFF, 1'b0, 4'd0, 4'd1,
         1'b1, 32'h0, 1'b1, 32'h0F0F_1234, -1, -1, 4'd0, 32'h0);
    // x0 still zero, x1 unchanged; x15 written with a pause at digit 3
    pass("x0_x1", 1'b1, 4'd15, 32'h1234_5678, 1'b0, 4'd0, 4'd1,
         1'b1, 32'h0, 1'b1, 32'h0F0F_1234, 3, -1, 4'd0, 32'h0);
    // x15 intact after pause; x7 = 3C3C3C3C
    pass("rd_x15", 1'b1, 4'd7, 32'h3C3C_3C3C, 1'b0, 4'd15, 4'd5,
         1'b1, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, -1, -1, 4'd0, 32'h0);
    // bypass on both ports
    pass("fwd_on", 1'b1, 4'd7, 32'hA5A5_A5A5, 1'b1, 4'd7, 4'd7,
         1'b1, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, -1, -1, 4'd0, 32'h0);
    // no bypass: old x7 value visible
    pass("fwd_off", 1'b1, 4'd7, 32'h5A5A_5A5A, 1'b0, 4'd7, 4'd7,
         1'b1, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, -1, -1, 4'd0, 32'h0);
    // write x3 with bypass enabled
    pass("wr_x3", 1'b1, 4'd3, 32'hCAFE_F00D, 1'b1, 4'd4, 4'd3,
         1'b1, X4Exp, 1'b1, X3Exp, -1, -1, 4'd0, 32'h0);
    // read x3/x4; rs1 switches to x1 at digit 16
    pass("rd_x3", 1'b0, 4'd0, 32'h0, 1'b0, 4'd3, 4'd4,
         1'b1, X3Exp, 1'b1, X4Exp, -1, 16, 4'd1, 32'h0F0F_1234);

    // reset in the middle of writing x9
    for (int k = 0; k < 17; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 4'd9, 4'd5,
          mk("wr_x9", 1'b0, 1'b0, 1'b1, beef[k], 1'b1, k, 1'b1, 1'b0));
    end
    cyc(1'b1, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 4'd9, 4'd5,
        mk("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 17, 1'b1, 1'b0));
    cyc(1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 4'd9, 4'd5,
        mk("post_rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0));
    pass("rd_x9", 1'b0, 4'd0, 32'h0, 1'b0, 4'd9, 4'd5,
         1'b1, 32'h0, 1'b1, 32'h0, -1, -1, 4'd0, 32'h0);

    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nanov_regfile_serial.md
NANOV_REGFILE_SERIAL -- requirements
Module: nanov_regfile_serial

Interface
REQ-001 Parameter XLEN, default 32, register width in bits.
REQ-002 Parameter DW, default 1, bits transferred per enabled cycle; legal values 1, 2, 4; XLEN SHALL be a multiple of DW.
REQ-003 Parameter NUM_REGS, default 16, architectural registers including x0; registers at index >= NUM_REGS read as zero.
REQ-004 Parameter REG_ADDR_BITS, default 4, width of register addresses.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 en  input  1  advance: rotate all registers and the digit counter by one digit.
REQ-008 rs1, rs2  input  REG_ADDR_BITS  read-port register selects.
REQ-009 rd  input  REG_ADDR_BITS  write register select.
REQ-010 wr_en  input  1  write the current digit of rd.
REQ-011 wr_data  input  DW  digit written to rd.
REQ-012 fwd_en  input  1  enable same-cycle write-to-read bypass.
REQ-013 rs1_data, rs2_data  output  DW  current digit of the selected register.
REQ-014 digit  output  log2(XLEN/DW)  index of the digit currently presented, 0 = least significant.
REQ-015 word_done  output  1  high while en=1 and digit = XLEN/DW-1.

Function
REQ-016 Each register 1..NUM_REGS-1 SHALL be an XLEN-bit ring, shifting right by DW on every cycle with en=1 and rst=0.
REQ-017 rsN_data SHALL be bits [DW-1:0] of the register selected by rsN, combinationally; x0 and out-of-range indices SHALL read 0.
REQ-018 On an enabled cycle with wr_en=1 and rd=i (i != 0, i < NUM_REGS), register i SHALL become {wr_data, reg_i[XLEN-1:DW]}; otherwise it SHALL become {reg_i[DW-1:0], reg_i[XLEN-1:DW]}.
REQ-019 Writes to x0 or out-of-range rd SHALL be discarded.
REQ-020 digit SHALL increment on each enabled cycle and wrap from XLEN/DW-1 to 0; after XLEN/DW enabled cycles every unwritten register SHALL hold its original value and alignment.
REQ-021 With en=0: no rotation, no write even if wr_en=1, digit held, rsN_data stable given stable selects.
REQ-022 Bypass: when fwd_en=1, wr_en=1, en=1, rd != 0 and rsN = rd, rsN_data SHALL equal wr_data in the same cycle; otherwise stored data.
REQ-023 Simultaneous rs1 = rs2 = rd with bypass active SHALL return wr_data on both ports.
REQ-024 Changing rs1/rs2/rd mid-word SHALL be legal; outputs follow the new select at the current digit.
REQ-025 Latency: a digit written at digit k SHALL be readable, without bypass, at digit k of the next word pass.

Reset
REQ-026 While rst=1 at a clock edge: all registers cleared to 0, digit = 0, independent of en and wr_en.
REQ-027 Reset values: rs1_data = rs2_data = 0, digit = 0, word_done = 0.
REQ-028 Reset asserted mid-word SHALL abandon the word; the first enabled cycle after release presents digit 0.

Configuration
REQ-029 Macro NANOV_REGFILE_CONST_REGS_EN defined: x3 SHALL read constant 0x00001000 and x4 constant 0x10000000, serialised by digit, bypass never applied to them, writes to them discarded, no storage for them.
REQ-030 Macro NANOV_REGFILE_CONST_REGS_EN undefined: x3 and x4 SHALL be ordinary storage registers.

Verification
REQ-031 DW=1: reset, write 0xDEADBEEF to x5 over 32 enabled cycles, read rs1=5 next pass -> bits LSB-first of 0xDEADBEEF, word_done on cycle 32.
REQ-032 DW=4: write 0x12345678 to x15, drop en for 5 cycles at digit 3 -> digit stays 3, no corruption, next pass reads nibbles 8,7,6,5,4,3,2,1.
REQ-033 Write 0xFFFFFFFF to x0 -> rs1=0 reads all zeros next pass; x1 unchanged.
REQ-034 fwd_en=1, rd=rs1=rs2=7, wr_data digits of 0xA5A5A5A5 -> both ports show 0xA5A5A5A5 same pass; with fwd_en=0 they show old x7 value.
REQ-035 Macro defined: rs1=3, rs2=4 -> 0x00001000, 0x10000000; write 0 to x3 -> still 0x00001000; macro undefined: x3 reads written value.
REQ-036 Assert rst at digit 17 mid-write to x9 -> x9 reads 0, digit = 0 after release.
